// File: rtl/prueba.sv
// PS/2 host controller: sends one command byte, receives device frames and
// supervises the device acknowledge to enter stream mode.
module prueba #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire        PS2CLK,
  inout  wire        PS2DATA,
  input  logic [7:0] datain,
  input  logic       tx_write,
  output logic       tx_done,
  output logic       rx_done,
  output logic [7:0] dataout,
  output logic [7:0] DatoRec,
  output logic       STREAM,
  output logic       FAIL
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_TX_BITS = 3'd3,
    S_TX_ACK  = 3'd4,
    S_RX_BITS = 3'd5
  } state_t;

  // Bit that makes the 9-bit {parity, byte} group carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_prev_r;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       idx_r, idx_nxt_s;
  logic [10:0]      tx_frame_r, tx_frame_nxt_s;
  logic [7:0]       rx_shift_r, rx_shift_nxt_s;
  logic             rx_par_r, rx_par_nxt_s;
  logic             clk_drive_r, data_drive_r, clk_drive_s, data_drive_s;
  logic             tx_done_r, rx_done_r, stream_r, fail_r, await_resp_r;
  logic [7:0]       dataout_r, dato_rec_r;
  logic             fall_s, ps2_data_s, timed_out_s;
  logic             tx_start_s, ack_ok_s, ack_bad_s, rx_end_s, rx_valid_s;
  logic             fail_set_s, stream_set_s;

  assign fall_s      = clk_prev_r & ~clk_sync_r[1];
  assign ps2_data_s  = data_sync_r[1];
  assign timed_out_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizers plus edge-detect history for the PS/2 lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], PS2CLK};
      data_sync_r <= {data_sync_r[0], PS2DATA};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  // Next-state logic: frame sequencing, bit counters and the no-edge timeout.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    idx_nxt_s      = idx_r;
    tx_frame_nxt_s = tx_frame_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_par_nxt_s   = rx_par_r;
    tx_start_s     = 1'b0;
    ack_ok_s       = 1'b0;
    ack_bad_s      = 1'b0;
    rx_end_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fall_s && !ps2_data_s) begin
          state_nxt_s = S_RX_BITS;
          cnt_nxt_s   = '0;
          idx_nxt_s   = 4'd0;
        end else if (tx_write) begin
          tx_start_s     = 1'b1;
          state_nxt_s    = S_INHIBIT;
          cnt_nxt_s      = '0;
          tx_frame_nxt_s = {1'b1, odd_parity(datain), datain, 1'b0};
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_r == CNT_W'(INHIBIT_CYCLES)) begin
          state_nxt_s = S_RTS;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      S_RTS: begin
        state_nxt_s = S_TX_BITS;
        cnt_nxt_s   = '0;
        idx_nxt_s   = 4'd0;
      end
      S_TX_BITS: begin
        if (fall_s) begin
          cnt_nxt_s = '0;
          idx_nxt_s = idx_r + 4'd1;
          if (idx_r == 4'd9) begin
            state_nxt_s = S_TX_ACK;
          end else begin
            state_nxt_s = S_TX_BITS;
          end
        end else if (timed_out_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      S_TX_ACK: begin
        if (fall_s) begin
          state_nxt_s = S_IDLE;
          if (!ps2_data_s) begin
            ack_ok_s = 1'b1;
          end else begin
            ack_bad_s = 1'b1;
          end
        end else if (timed_out_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      S_RX_BITS: begin
        if (fall_s) begin
          cnt_nxt_s = '0;
          idx_nxt_s = idx_r + 4'd1;
          if (idx_r < 4'd8) begin
            rx_shift_nxt_s = {ps2_data_s, rx_shift_r[7:1]};
          end else if (idx_r == 4'd8) begin
            rx_par_nxt_s = ps2_data_s;
          end else begin
            rx_end_s    = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end else if (timed_out_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output logic: line drives follow the next state so they register with it.
  always_comb begin
    clk_drive_s  = 1'b0;
    data_drive_s = 1'b0;
    case (state_nxt_s)
      S_INHIBIT: clk_drive_s = 1'b1;
      S_RTS: begin
        clk_drive_s  = 1'b1;
        data_drive_s = 1'b1;
      end
      S_TX_BITS: data_drive_s = ~tx_frame_nxt_s[idx_nxt_s];
      default: begin
        clk_drive_s  = 1'b0;
        data_drive_s = 1'b0;
      end
    endcase
    rx_valid_s   = rx_end_s & ps2_data_s & (^{rx_par_r, rx_shift_r});
    stream_set_s = rx_valid_s & await_resp_r & (rx_shift_r == 8'hFA);
    fail_set_s   = ack_bad_s | (rx_end_s & ~rx_valid_s)
                 | (timed_out_s & ~fall_s &
                    ((state_r == S_TX_BITS) | (state_r == S_TX_ACK) | (state_r == S_RX_BITS)))
                 | (rx_valid_s & await_resp_r & ((rx_shift_r == 8'hFE) | (rx_shift_r == 8'hFC)));
  end

  // State, datapath and registered outputs including the supervisor flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      idx_r        <= 4'd0;
      tx_frame_r   <= 11'd0;
      rx_shift_r   <= 8'd0;
      rx_par_r     <= 1'b0;
      clk_drive_r  <= 1'b0;
      data_drive_r <= 1'b0;
      tx_done_r    <= 1'b0;
      rx_done_r    <= 1'b0;
      dataout_r    <= 8'd0;
      dato_rec_r   <= 8'd0;
      stream_r     <= 1'b0;
      fail_r       <= 1'b0;
      await_resp_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      tx_frame_r   <= tx_frame_nxt_s;
      rx_shift_r   <= rx_shift_nxt_s;
      rx_par_r     <= rx_par_nxt_s;
      clk_drive_r  <= clk_drive_s;
      data_drive_r <= data_drive_s;
      tx_done_r    <= ack_ok_s;
      rx_done_r    <= rx_valid_s;
      if (rx_valid_s) begin
        dataout_r <= rx_shift_r;
      end
      if (rx_valid_s && stream_r) begin
        dato_rec_r <= rx_shift_r;
      end
      if (stream_set_s) begin
        stream_r <= 1'b1;
      end
      if (tx_start_s) begin
        fail_r <= 1'b0;
      end else if (fail_set_s) begin
        fail_r <= 1'b1;
      end
      // Only the first valid byte after an acknowledged command is a response.
      if (tx_start_s) begin
        await_resp_r <= 1'b0;
      end else if (ack_ok_s) begin
        await_resp_r <= 1'b1;
      end else if (rx_valid_s) begin
        await_resp_r <= 1'b0;
      end
    end
  end

  assign PS2CLK  = clk_drive_r  ? 1'b0 : 1'bz;
  assign PS2DATA = data_drive_r ? 1'b0 : 1'bz;
  assign tx_done = tx_done_r;
  assign rx_done = rx_done_r;
  assign dataout = dataout_r;
  assign DatoRec = dato_rec_r;
  assign STREAM  = stream_r;
  assign FAIL    = fail_r;

endmodule

// File: tb/tb_prueba.sv
// Scoreboard bench for prueba: a PS/2 device model exchanges frames with the
// host; expected bytes are queued at stimulus time and popped on DUT output.
module tb_prueba;

  localparam int INHIBIT = 50;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 10;
  localparam int Q       = 200;
  localparam int H       = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain;
  logic       tx_write;
  logic       tx_done, rx_done, stream, fail;
  logic [7:0] dataout, dato_rec;
  wire        ps2clk, ps2data;
  logic       dev_clk_lo  = 1'b0;
  logic       dev_data_lo = 1'b0;

  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk  = dev_clk_lo  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_lo ? 1'b0 : 1'bz;

  prueba #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .PS2CLK(ps2clk), .PS2DATA(ps2data),
    .datain(datain), .tx_write(tx_write), .tx_done(tx_done), .rx_done(rx_done),
    .dataout(dataout), .DatoRec(dato_rec), .STREAM(stream), .FAIL(fail)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_t0 = 0;
  int tx_done_hi = 0;
  int rx_done_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  always #HALF clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: every rx_done pops one expected byte.
  initial forever begin
    @(negedge clk);
    if (!rst && tx_done) tx_done_hi++;
    if (!rst && rx_done) begin
      rx_done_cnt++;
      if (rx_exp_q.size() == 0) check_eq("rx_unexpected", 32'(rx_exp_q.size()), 32'd1);
      else check_eq("rx_data", 32'(dataout), 32'(rx_exp_q.pop_front()));
    end
  end

  task automatic host_tx(input logic [7:0] b);
    @(negedge clk);
    datain   = b;
    tx_write = 1'b1;
    tx_exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_t0 = cyc;
    repeat (4) @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic dev_send(input logic [7:0] b, input bit bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (!bad_par) rx_exp_q.push_back(b);
    for (int i = 0; i < 11; i++) begin
      dev_data_lo = ~fr[i];
      #Q; dev_clk_lo = 1'b1;
      #H; dev_clk_lo = 1'b0;
      #Q;
    end
    dev_data_lo = 1'b0;
    #(Q * 4);
  endtask

  task automatic dev_get_cmd();
    int n, lo, dlo_cyc;
    logic [9:0] got;
    logic [7:0] exp_b;
    n = 0;
    while (ps2clk !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("inhibit_seen", 32'(ps2clk), 32'd0);
    lo = 0;
    dlo_cyc = -1;
    while (ps2clk === 1'b0 && lo < 5000) begin
      @(negedge clk);
      lo++;
      if (dlo_cyc < 0 && ps2data === 1'b0) dlo_cyc = cyc;
    end
    check_eq("inhibit_long", 32'(lo >= INHIBIT), 32'd1);
    check_eq("start_delay", 32'(dlo_cyc - tx_t0), 32'(INHIBIT + 1));
    check_eq("start_bit", 32'(ps2data), 32'd0);
    #Q;
    for (int i = 0; i < 10; i++) begin
      dev_clk_lo = 1'b1;
      #H; dev_clk_lo = 1'b0;
      #Q; got[i] = ps2data;
      #Q;
    end
    dev_data_lo = 1'b1;
    #Q; dev_clk_lo = 1'b1;
    #H; dev_clk_lo = 1'b0;
    #Q; dev_data_lo = 1'b0;
    #Q;
    exp_b = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'h00;
    check_eq("tx_byte", 32'(got[7:0]), 32'(exp_b));
    check_eq("tx_parity", 32'(got[8]), 32'(~^exp_b));
    check_eq("tx_stop", 32'(got[9]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] stream_bytes [3];
    stream_bytes = '{8'h08, 8'h12, 8'hFE};
    rst = 1'b1;
    tx_write = 1'b0;
    datain = 8'h00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_done", 32'(tx_done), 32'd0);
    check_eq("rst_rx_done", 32'(rx_done), 32'd0);
    check_eq("rst_stream", 32'(stream), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);
    check_eq("rst_dataout", 32'(dataout), 32'd0);
    check_eq("rst_datorec", 32'(dato_rec), 32'd0);
    check_eq("rst_ps2clk", 32'(ps2clk), 32'd1);
    check_eq("rst_ps2data", 32'(ps2data), 32'd1);
    rst = 1'b0;

    // Command 0xF4 with an acknowledging device.
    fork
      host_tx(8'hF4);
      dev_get_cmd();
    join
    repeat (5) @(negedge clk);
    check_eq("tx_done_pulse", 32'(tx_done_hi), 32'd1);
    check_eq("fail_after_tx", 32'(fail), 32'd0);
    check_eq("stream_before_fa", 32'(stream), 32'd0);

    dev_send(8'hFA, 1'b0);
    check_eq("stream_set", 32'(stream), 32'd1);
    check_eq("fail_after_fa", 32'(fail), 32'd0);
    check_eq("dataout_fa", 32'(dataout), 32'hFA);

    foreach (stream_bytes[i]) begin
      dev_send(stream_bytes[i], 1'b0);
      check_eq("datorec", 32'(dato_rec), 32'(stream_bytes[i]));
    end
    check_eq("stream_kept", 32'(stream), 32'd1);
    check_eq("fail_fe_stream", 32'(fail), 32'd0);
    check_eq("rx_count4", 32'(rx_done_cnt), 32'd4);

    // Bad parity frame.
    dev_send(8'h55, 1'b1);
    check_eq("fail_parity", 32'(fail), 32'd1);
    check_eq("dataout_kept", 32'(dataout), 32'hFE);
    check_eq("rx_count_bad", 32'(rx_done_cnt), 32'd4);

    // No device responding: inhibit, start bit, then timeout.
    host_tx(8'hA5);
    void'(tx_exp_q.pop_front());
    check_eq("fail_cleared", 32'(fail), 32'd0);
    @(negedge clk);
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
    n = 0;
    while (ps2data !== 1'b0 && n < INHIBIT + 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_delay_2", 32'(cyc - tx_t0), 32'(INHIBIT + 1));
    n = 0;
    while (fail !== 1'b1 && n < TIMEOUT + 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_fail", 32'(fail), 32'd1);
    check_eq("timeout_window",
             32'((cyc - tx_t0 >= TIMEOUT) && (cyc - tx_t0 <= INHIBIT + TIMEOUT + 10)), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("to_ps2clk", 32'(ps2clk), 32'd1);
    check_eq("to_ps2data", 32'(ps2data), 32'd1);
    check_eq("no_tx_done", 32'(tx_done_hi), 32'd1);

    // Back in idle: a fresh device frame is accepted.
    dev_send(8'h3C, 1'b0);
    check_eq("datorec_3c", 32'(dato_rec), 32'h3C);
    check_eq("rx_count5", 32'(rx_done_cnt), 32'd5);
    check_eq("fail_sticky", 32'(fail), 32'd1);
    check_eq("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
